// File: rtl/tick_controller.sv
// tick_controller: releases one registered single-cycle tick per rising edge of a selectable
// divided_clocks tap, under run/pause control. Define TICK_CTRL_STEP_EN for single-step support.
module tick_controller #(
   parameter int WIDTH       = 32,
   parameter int SELW        = 5,
   parameter int DEFAULT_SEL = 23,
   parameter int CNTW        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] divided_clocks,
   input  logic [SELW-1:0]  rate_sel,
   input  logic             run,
   input  logic             step,
   output logic             tick,
   output logic [SELW-1:0]  active_sel,
   output logic             running,
   output logic [CNTW-1:0]  tick_count
);

`ifdef TICK_CTRL_STEP_EN
   typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

   state_t          state_reg;
   logic            tap_q;
   logic            tap;
   logic            tap_edge;
   logic [SELW-1:0] sel_req;
   logic            issue;
   logic            apply_sel;

   assign sel_req  = (32'(rate_sel) >= 32'(WIDTH)) ? SELW'(WIDTH - 1) : rate_sel;
   assign tap      = divided_clocks[active_sel];
   assign tap_edge = tap & ~tap_q;

`ifdef TICK_CTRL_STEP_EN
   logic step_q;
   logic step_req;

   assign step_req = step & ~step_q;
   assign issue    = tap_edge & (((state_reg == RUN) & run) | (state_reg == STEP_WAIT));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step;
      end
   end
`else
   logic unused_step;

   assign unused_step = step;
   assign issue       = tap_edge & (state_reg == RUN) & run;
`endif

   // A new rate only lands between periods: at once when idle, otherwise on a tick edge
   assign apply_sel = (sel_req != active_sel) & ((state_reg == IDLE) | issue);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         tick       <= 1'b0;
         active_sel <= SELW'(DEFAULT_SEL);
         running    <= 1'b0;
         tick_count <= '0;
         tap_q      <= 1'b0;
      end else begin
         tick <= issue;
         if (issue) begin
            tick_count <= tick_count + CNTW'(1);
         end
         // Preloading tap_q from the new tap keeps a rate switch from faking an edge
         if (apply_sel) begin
            active_sel <= sel_req;
            tap_q      <= divided_clocks[sel_req];
         end else begin
            tap_q <= tap;
         end
         case (state_reg)
            IDLE: begin
               if (run) begin
                  state_reg <= RUN;
                  running   <= 1'b1;
               end
`ifdef TICK_CTRL_STEP_EN
               else if (step_req) begin
                  state_reg <= STEP_WAIT;
               end
`endif
            end
            RUN: begin
               if (tap_edge && !run) begin
                  state_reg <= IDLE;
                  running   <= 1'b0;
               end
            end
`ifdef TICK_CTRL_STEP_EN
            STEP_WAIT: begin
               if (tap_edge) begin
                  if (run) begin
                     state_reg <= RUN;
                     running   <= 1'b1;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
`endif
            default: begin
               state_reg <= IDLE;
               running   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_controller.sv
// Self-checking bench for tick_controller against a rule-level behavioural model.
// Works with TICK_CTRL_STEP_EN defined or undefined.
module tb_tick_controller;

   localparam int WIDTH       = 24;
   localparam int SELW        = 5;
   localparam int DEFAULT_SEL = 23;
   localparam int CNTW        = 8;
   localparam int CNT_MOD     = 1 << CNTW;
`ifdef TICK_CTRL_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] divided_clocks = '0;
   logic [SELW-1:0]  rate_sel = 5'd23;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic             tick;
   logic [SELW-1:0]  active_sel;
   logic             running;
   logic [CNTW-1:0]  tick_count;

   int checks = 0;
   int errors = 0;

   // behavioural model: mode 0 = paused, 1 = free running, 2 = waiting for a single step
   int m_mode, m_sel, m_count;
   bit m_tapq, m_stepq, m_tick, m_running;

   tick_controller #(
      .WIDTH(WIDTH), .SELW(SELW), .DEFAULT_SEL(DEFAULT_SEL), .CNTW(CNTW)
   ) dut (
      .clock(clock), .reset(reset), .divided_clocks(divided_clocks), .rate_sel(rate_sel),
      .run(run), .step(step), .tick(tick), .active_sel(active_sel), .running(running),
      .tick_count(tick_count)
   );

   always #5 clock = ~clock;

   function automatic void model_reset();
      m_mode = 0; m_sel = DEFAULT_SEL; m_count = 0;
      m_tapq = 0; m_stepq = 0; m_tick = 0; m_running = 0;
   endfunction

   function automatic void model_clock();
      int old_mode, tapv, want;
      bit rise, step_rise, fire;
      if (reset) begin
         model_reset();
         return;
      end
      old_mode  = m_mode;
      tapv      = (int'(divided_clocks) >> m_sel) & 1;
      rise      = (tapv == 1) && !m_tapq;
      step_rise = STEP_EN && step && !m_stepq;
      want      = (int'(rate_sel) > WIDTH - 1) ? WIDTH - 1 : int'(rate_sel);
      fire      = 0;
      if (old_mode == 0) begin
         if (run) m_mode = 1;
         else if (step_rise) m_mode = 2;
      end else if (rise) begin
         if (old_mode == 2) begin
            fire = 1;
            m_mode = run ? 1 : 0;
         end else if (run) begin
            fire = 1;
         end else begin
            m_mode = 0;
         end
      end
      m_tick = fire;
      if (fire) m_count = (m_count + 1) % CNT_MOD;
      if (want != m_sel && (old_mode == 0 || fire)) begin
         m_sel  = want;
         m_tapq = ((int'(divided_clocks) >> want) & 1) == 1;
      end else begin
         m_tapq = (tapv == 1);
      end
      m_stepq   = step;
      m_running = (m_mode == 1);
   endfunction

   // one clock: model updates on the active edge, counter bus advances on the falling edge
   task automatic cycle();
      @(posedge clock);
      model_clock();
      @(negedge clock);
      divided_clocks = divided_clocks + 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      run = 0; step = 0; rate_sel = 5'd23;
      do_reset();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", tick); end
      checks++; if (active_sel !== 5'd23) begin errors++; $display("FAIL reset_sel got %0d want 23", active_sel); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", running); end
      checks++; if (tick_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", tick_count); end
      $display("test_reset done");
   endtask

   task automatic test_run_fast();
      int first_at;
      int pulses;
      bit exp_tick;
      do_reset();
      run = 1; rate_sel = 0;
      first_at = 0;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         if (tick === 1'b1) begin first_at = i; break; end
      end
      checks++; if (first_at == 0) begin errors++; $display("FAIL first_tick none within 3 cycles want <=3"); end
      pulses = (first_at != 0) ? 1 : 0;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         exp_tick = (i % 2 == 0);
         if (tick === 1'b1) pulses++;
         checks++;
         if (tick !== exp_tick) begin errors++; $display("FAIL period2 cycle %0d got %0b want %0b", i, tick, exp_tick); end
      end
      checks++; if (pulses != 5) begin errors++; $display("FAIL pulse_total got %0d want 5", pulses); end
      checks++; if (tick_count !== 8'd5) begin errors++; $display("FAIL count5 got %0d want 5", tick_count); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %0b want 1", running); end
      $display("test_run_fast done first_at=%0d pulses=%0d", first_at, pulses);
   endtask

   task automatic test_rate_change();
      int gap;
      bit seen;
      do_reset();
      run = 1; rate_sel = 2;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin cycle(); seen = (tick === 1'b1); end
      checks++; if (!seen) begin errors++; $display("FAIL rate2_first no tick in 20 cycles"); end
      gap = 0; seen = 0;
      for (int i = 0; i < 3; i++) begin cycle(); gap++; end
      rate_sel = 0;
      cycle(); gap++;
      checks++; if (active_sel !== 5'd2) begin errors++; $display("FAIL sel_held got %0d want 2", active_sel); end
      for (int i = 0; i < 12 && !seen; i++) begin cycle(); gap++; seen = (tick === 1'b1); end
      checks++; if (gap != 8) begin errors++; $display("FAIL old_period got %0d want 8", gap); end
      checks++; if (active_sel !== 5'd0) begin errors++; $display("FAIL sel_on_tick got %0d want 0", active_sel); end
      // the first fast pulse may follow immediately; measure the settled period after it
      seen = 0;
      for (int i = 0; i < 4 && !seen; i++) begin cycle(); seen = (tick === 1'b1); end
      for (int k = 0; k < 2; k++) begin
         gap = 0; seen = 0;
         for (int i = 0; i < 6 && !seen; i++) begin cycle(); gap++; seen = (tick === 1'b1); end
         checks++; if (gap != 2) begin errors++; $display("FAIL new_period got %0d want 2", gap); end
      end
      checks++; if (tick_count !== 8'(m_count)) begin errors++; $display("FAIL rate_count got %0d want %0d", tick_count, m_count); end
      $display("test_rate_change done");
   endtask

   task automatic test_step();
      int ticks;
      int exp_ticks;
      do_reset();
      run = 0; rate_sel = 1;
      repeat (3) cycle();
      exp_ticks = STEP_EN ? 1 : 0;
      step = 1; cycle(); step = 0;
      ticks = (tick === 1'b1) ? 1 : 0;
      for (int i = 0; i < 7; i++) begin cycle(); if (tick === 1'b1) ticks++; end
      checks++; if (ticks != exp_ticks) begin errors++; $display("FAIL step_once got %0d ticks want %0d", ticks, exp_ticks); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_idle running got %0b want 0", running); end
      checks++; if (tick_count !== 8'(exp_ticks)) begin errors++; $display("FAIL step_count got %0d want %0d", tick_count, exp_ticks); end
      step = 1; ticks = 0;
      for (int i = 0; i < 16; i++) begin cycle(); if (tick === 1'b1) ticks++; end
      step = 0;
      checks++; if (ticks != exp_ticks) begin errors++; $display("FAIL step_hold got %0d ticks want %0d", ticks, exp_ticks); end
      $display("test_step done step_en=%0b", STEP_EN);
   endtask

   task automatic test_run_step_same();
      int ticks;
      do_reset();
      run = 0; step = 0; rate_sel = 0;
      repeat (2) cycle();
      run = 1; step = 1;
      cycle();
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL same_cycle running got %0b want 1", running); end
      ticks = 0;
      for (int i = 0; i < 6; i++) begin cycle(); if (tick === 1'b1) ticks++; end
      step = 0;
      checks++; if (ticks != 3) begin errors++; $display("FAIL same_cycle ticks got %0d want 3", ticks); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL same_cycle still_running got %0b want 1", running); end
      $display("test_run_step_same done");
   endtask

   task automatic test_wrap();
      bit reached;
      bit seen;
      do_reset();
      run = 1; rate_sel = 0;
      reached = 0;
      for (int i = 0; i < 700 && !reached; i++) begin cycle(); reached = (m_count == CNT_MOD - 1); end
      checks++; if (!reached || tick_count !== 8'hFF) begin errors++; $display("FAIL count_max got %0d want 255", tick_count); end
      seen = 0;
      for (int i = 0; i < 4 && !seen; i++) begin cycle(); seen = (tick === 1'b1); end
      checks++; if (!seen || tick_count !== 8'h00) begin errors++; $display("FAIL count_wrap got %0d want 0", tick_count); end
      $display("test_wrap done");
   endtask

   task automatic test_async_reset();
      do_reset();
      run = 1; rate_sel = 3;
      repeat (40) cycle();
      #2 reset = 1'b1;
      #1;
      model_reset();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_tick got %0b want 0", tick); end
      checks++; if (active_sel !== 5'd23) begin errors++; $display("FAIL async_sel got %0d want 23", active_sel); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_running got %0b want 0", running); end
      checks++; if (tick_count !== 8'd0) begin errors++; $display("FAIL async_count got %0d want 0", tick_count); end
      divided_clocks = '1;
      cycle();
      reset = 1'b0;
      cycle();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL post_reset_tick got %0b want 0", tick); end
      $display("test_async_reset done");
   endtask

   task automatic test_clamp();
      int reqs [4] = '{5, 31, 10, 24};
      int exps [4] = '{5, 23, 10, 23};
      do_reset();
      run = 0;
      for (int i = 0; i < 4; i++) begin
         rate_sel = 5'(reqs[i]);
         cycle();
         checks++;
         if (active_sel !== 5'(exps[i])) begin
            errors++; $display("FAIL clamp req %0d got %0d want %0d", reqs[i], active_sel, exps[i]);
         end
      end
      $display("test_clamp done");
   endtask

   task automatic test_random();
      int bad;
      do_reset();
      divided_clocks = WIDTH'($urandom);
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         if ($urandom_range(0, 3) == 0) step = ~step;
         if ($urandom_range(0, 40) == 0)
            rate_sel = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         cycle();
         checks++;
         if ({tick, active_sel, running, tick_count} !== {m_tick, 5'(m_sel), m_running, 8'(m_count)}) begin
            errors++;
            if (bad < 10)
               $display("FAIL random cycle %0d got tick=%0b sel=%0d run=%0b cnt=%0d want tick=%0b sel=%0d run=%0b cnt=%0d",
                        i, tick, active_sel, running, tick_count, m_tick, m_sel, m_running, m_count);
            bad++;
         end
      end
      run = 0; step = 0;
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_fast();
      test_rate_change();
      test_step();
      test_run_step_same();
      test_wrap();
      test_async_reset();
      test_clamp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
